// File: rtl/mem_arbiter_rr_if.sv
// Bundle between the L1-side clients / L2 port and mem_arbiter_rr.
// Handshake: req_read/req_write are levels held until the one-cycle req_resp; mem_read/mem_write are held until mem_resp.
interface mem_arbiter_rr_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]        req_read;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_address;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        req_resp;
  logic [DATA_W-1:0]        req_rdata;
  logic [ID_W-1:0]          grant_id;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_address;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_resp;
  logic [DATA_W-1:0]        mem_rdata;

  // Environment side: clients and the L2 memory model.
  modport master (
    output req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
    input  req_resp, req_rdata, grant_id, mem_read, mem_write, mem_address, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
    output req_resp, req_rdata, grant_id, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter onto a single L2 port with registered request/response paths.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise highest-index channel wins.
module mem_arbiter_rr #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_arbiter_rr_if.slave    bus,
  output logic [1:0]         state
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t            st;
  logic [NUM_CH-1:0] active;
  logic [ID_W-1:0]   win;

  assign state  = st;
  assign active = bus.req_read | bus.req_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr;
  int              idx;

  // Scan downward from ptr+NUM_CH-1 so the channel closest to ptr is assigned last and wins.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (active[idx]) win = ID_W'(idx);
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active[i]) win = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st              <= IDLE;
      bus.req_resp    <= '0;
      bus.req_rdata   <= '0;
      bus.grant_id    <= '0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr             <= '0;
`endif
    end else begin
      bus.req_resp <= '0;
      case (st)
        IDLE: begin
          if (|active) begin
            // A channel asserting both read and write is treated as a write.
            bus.mem_write   <= bus.req_write[win];
            bus.mem_read    <= ~bus.req_write[win];
            bus.mem_address <= bus.req_address[win*ADDR_W +: ADDR_W];
            bus.mem_wdata   <= bus.req_wdata[win*DATA_W +: DATA_W];
            bus.grant_id    <= win;
`ifdef ARB_ROUND_ROBIN_EN
            ptr             <= (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
`endif
            st              <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_resp) begin
            if (bus.mem_read) bus.req_rdata <= bus.mem_rdata;
            bus.mem_read           <= 1'b0;
            bus.mem_write          <= 1'b0;
            bus.req_resp[bus.grant_id] <= 1'b1;
            st                     <= RESP;
          end
        end
        RESP: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a 2-channel instance for the main scenarios and a 4-channel one for grant order.
module tb_mem_arbiter_rr;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state2, state4;
  int         tests = 0;
  int         failed = 0;

  localparam logic [127:0] DEAD = 128'hDEADDEADDEADDEADDEADDEADDEADDEAD;
  localparam logic [127:0] CAFE = 128'hCAFE0000CAFE1111CAFE2222CAFE3333;
  localparam logic [127:0] JUNK = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;

  mem_arbiter_rr_if #(.NUM_CH(2), .ADDR_W(16), .DATA_W(128)) b2 ();
  mem_arbiter_rr_if #(.NUM_CH(4), .ADDR_W(16), .DATA_W(128)) b4 ();

  mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(16), .DATA_W(128)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .state(state2));
  mem_arbiter_rr #(.NUM_CH(4), .ADDR_W(16), .DATA_W(128)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .state(state4));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy2();
    int n = 0;
    while (!(b2.mem_read || b2.mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy2_wait", 128'(n < 20), 128'd1);
  endtask

  task automatic wait_busy4();
    int n = 0;
    while (!(b4.mem_read || b4.mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy4_wait", 128'(n < 20), 128'd1);
  endtask

  // Called at a BUSY negedge; returns at the RESP negedge.
  task automatic resp2(input int gap, input logic [127:0] rd);
    for (int g = 0; g < gap; g++) begin
      check("no_early_resp", b2.req_resp, 0);
      @(negedge clk);
    end
    b2.mem_rdata = rd;
    b2.mem_resp  = 1'b1;
    @(negedge clk);
    b2.mem_resp  = 1'b0;
  endtask

  initial begin
    int first, second, last;
    int exp4[5];
    logic [127:0] exp_rd1;

    b2.req_read = '0; b2.req_write = '0; b2.req_address = '0; b2.req_wdata = '0;
    b2.mem_resp = 1'b0; b2.mem_rdata = '0;
    b4.req_read = '0; b4.req_write = '0; b4.req_address = '0; b4.req_wdata = '0;
    b4.mem_resp = 1'b0; b4.mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_state", state2, 0);
    check("rst_mem_read", b2.mem_read, 0);
    check("rst_req_resp", b2.req_resp, 0);
    check("rst_grant_id", b2.grant_id, 0);
    check("rst_req_rdata", b2.req_rdata, 0);
    check("rst_mem_address", b2.mem_address, 0);

    // Single read on ch0, mem_resp 3 cycles after mem_read rises
    b2.req_address[15:0] = 16'h1230;
    b2.req_read = 2'b01;
    @(negedge clk);
    check("rd_mem_read", b2.mem_read, 1);
    check("rd_mem_write", b2.mem_write, 0);
    check("rd_mem_address", b2.mem_address, 16'h1230);
    check("rd_grant_id", b2.grant_id, 0);
    resp2(3, DEAD);
    check("rd_req_resp", b2.req_resp, 2'b01);
    check("rd_req_rdata", b2.req_rdata, DEAD);
    check("rd_mem_read_off", b2.mem_read, 0);
    b2.req_read = 2'b00;
    @(negedge clk);
    check("rd_resp_one_cycle", b2.req_resp, 0);
    check("rd_back_idle", state2, 0);

    // ch1 write; upstream address/wdata change while BUSY must not leak through
    b2.req_address[31:16] = 16'h4560;
    b2.req_wdata[255:128] = 128'h1111;
    b2.req_write = 2'b10;
    @(negedge clk);
    check("wr_mem_write", b2.mem_write, 1);
    check("wr_mem_read", b2.mem_read, 0);
    check("wr_grant_id", b2.grant_id, 1);
    b2.req_address[31:16] = 16'hFFFF;
    b2.req_wdata[255:128] = 128'h2222;
    resp2(2, JUNK);
    check("wr_addr_held", b2.mem_address, 16'h4560);
    check("wr_wdata_held", b2.mem_wdata, 128'h1111);
    check("wr_req_resp", b2.req_resp, 2'b10);
    check("wr_rdata_kept", b2.req_rdata, DEAD);
    check("wr_mem_write_off", b2.mem_write, 0);
    b2.req_write = 2'b00;
    @(negedge clk);

    // Reset asserted during BUSY
    b2.req_address[15:0] = 16'h0300;
    b2.req_read = 2'b01;
    @(negedge clk);
    check("rstb_busy", b2.mem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstb_mem_read_async", b2.mem_read, 0);
    check("rstb_state", state2, 0);
    check("rstb_addr", b2.mem_address, 0);
    b2.req_read = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    b2.mem_resp = 1'b1;
    @(negedge clk);
    b2.mem_resp = 1'b0;
    check("stray_resp_state", state2, 0);
    check("stray_resp_no_pulse", b2.req_resp, 0);
    @(negedge clk);
    check("rstb_no_resp", b2.req_resp, 0);

    // Simultaneous ch0 read and ch1 write
`ifdef ARB_ROUND_ROBIN_EN
    first = 0; second = 1;
`else
    first = 1; second = 0;
`endif
    b2.req_address = {16'h0200, 16'h0100};
    b2.req_wdata[255:128] = 128'hBEEF;
    b2.req_read = 2'b01;
    b2.req_write = 2'b10;
    @(negedge clk);
    check("sim1_grant", b2.grant_id, first);
    check("sim1_mem_write", b2.mem_write, 128'(first == 1));
    check("sim1_mem_read", b2.mem_read, 128'(first == 0));
    check("sim1_addr", b2.mem_address, (first == 1) ? 16'h0200 : 16'h0100);
    resp2(1, (first == 0) ? CAFE : JUNK);
    exp_rd1 = (first == 0) ? CAFE : 128'd0;
    check("sim1_req_resp", b2.req_resp, 1 << first);
    check("sim1_rdata", b2.req_rdata, exp_rd1);
    if (first == 0) b2.req_read = 2'b00; else b2.req_write = 2'b00;
    @(negedge clk);
    wait_busy2();
    check("sim2_grant", b2.grant_id, second);
    check("sim2_mem_write", b2.mem_write, 128'(second == 1));
    check("sim2_addr", b2.mem_address, (second == 1) ? 16'h0200 : 16'h0100);
    if (second == 1) check("sim2_wdata", b2.mem_wdata, 128'hBEEF);
    resp2(1, (second == 0) ? CAFE : JUNK);
    check("sim2_req_resp", b2.req_resp, 1 << second);
    check("sim2_rdata", b2.req_rdata, CAFE);
    b2.req_read = 2'b00;
    b2.req_write = 2'b00;
    @(negedge clk);

    // Four channels requesting continuously
`ifdef ARB_ROUND_ROBIN_EN
    exp4 = '{0, 1, 2, 3, 0};
`else
    exp4 = '{3, 2, 3, 2, 3};
`endif
    b4.req_address = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
    b4.req_read = 4'hF;
    last = -1;
    for (int i = 0; i < 5; i++) begin
      wait_busy4();
      check("ch4_grant", b4.grant_id, exp4[i]);
      check("ch4_addr", b4.mem_address, 16'h0A00 + exp4[i]);
      if (last >= 0) b4.req_read[last] = 1'b1;
      b4.mem_rdata = 128'(i + 1);
      b4.mem_resp = 1'b1;
      @(negedge clk);
      b4.mem_resp = 1'b0;
      check("ch4_resp", b4.req_resp, 1 << exp4[i]);
      check("ch4_rdata", b4.req_rdata, i + 1);
      b4.req_read[exp4[i]] = 1'b0;
      last = exp4[i];
      @(negedge clk);
    end
    b4.req_read = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
